// File: rtl/keypad_sprite_mover.sv
// Keypad-driven sprite tile mover for a text-mode VGA character grid.
// Clears the screen at reset or on request, then erases and redraws the sprite on each accepted move.
module keypad_sprite_mover #(
  parameter int COLS        = 80,
  parameter int ROWS        = 30,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int START_COL   = 10,
  parameter int START_ROW   = 10,
  parameter int WRAP        = 1,
  parameter int MOVE_DELAY  = 100,
  parameter logic [DATA_W-1:0] SPRITE_TILE = 16'h0e01,
  parameter logic [DATA_W-1:0] BG_TILE     = 16'h0000,
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       timer,
  input  logic [7:0]        keypad,
  output logic [ADDR_W-1:0] vga_addr,
  output logic              vga_we,
  output logic [DATA_W-1:0] vga_data,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row,
  output logic              busy
);

  typedef enum logic [1:0] {CLEAR, DRAW, IDLE, ERASE} state_t;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [COL_W-1:0]  MAX_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  MAX_ROW   = ROW_W'(ROWS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [31:0]       next_time;
  logic [31:0]       time_diff;
  logic              due;
  logic [COL_W-1:0]  tgt_col, nxt_col;
  logic [ROW_W-1:0]  tgt_row, nxt_row;
  logic              move_ok;
  logic [ADDR_W-1:0] cell_addr;
  logic              unused_keys;

  assign unused_keys = ^keypad[7:5];
  assign cell_addr   = ADDR_W'(cur_row) * ADDR_W'(COLS) + ADDR_W'(cur_col);
  // Signed difference keeps the rate limit correct across timer wrap
  assign time_diff   = timer - next_time;
  assign due         = ~time_diff[31];
  assign busy        = (state != IDLE);

  // Target cell for the highest-priority direction key; move_ok is low when clamping refuses it
  always_comb begin
    nxt_col = cur_col;
    nxt_row = cur_row;
    move_ok = 1'b0;
    if (keypad[0]) begin
      move_ok = (cur_col != '0) || (WRAP != 0);
      nxt_col = (cur_col == '0) ? MAX_COL : cur_col - COL_W'(1);
    end else if (keypad[1]) begin
      move_ok = (cur_col != MAX_COL) || (WRAP != 0);
      nxt_col = (cur_col == MAX_COL) ? '0 : cur_col + COL_W'(1);
    end else if (keypad[2]) begin
      move_ok = (cur_row != MAX_ROW) || (WRAP != 0);
      nxt_row = (cur_row == MAX_ROW) ? '0 : cur_row + ROW_W'(1);
    end else if (keypad[3]) begin
      move_ok = (cur_row != '0) || (WRAP != 0);
      nxt_row = (cur_row == '0) ? MAX_ROW : cur_row - ROW_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      next_time <= '0;
      cur_col   <= COL_W'(START_COL);
      cur_row   <= ROW_W'(START_ROW);
      tgt_col   <= '0;
      tgt_row   <= '0;
      vga_we    <= 1'b0;
      vga_addr  <= '0;
      vga_data  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          vga_we   <= 1'b1;
          vga_addr <= clr_cnt;
          vga_data <= BG_TILE;
          if (clr_cnt == LAST_CELL) state <= DRAW;
          else clr_cnt <= clr_cnt + ADDR_W'(1);
        end
        DRAW: begin
          vga_we    <= 1'b1;
          vga_addr  <= cell_addr;
          vga_data  <= SPRITE_TILE;
          next_time <= timer + 32'(MOVE_DELAY);
          state     <= IDLE;
        end
        IDLE: begin
          vga_we <= 1'b0;
          if (due) begin
            if (keypad[4]) begin
              clr_cnt <= '0;
              state   <= CLEAR;
            end else if (move_ok) begin
              tgt_col <= nxt_col;
              tgt_row <= nxt_row;
              state   <= ERASE;
            end
          end
        end
        ERASE: begin
          vga_we   <= 1'b1;
          vga_addr <= cell_addr;
          vga_data <= BG_TILE;
          cur_col  <= tgt_col;
          cur_row  <= tgt_row;
          state    <= DRAW;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_sprite_mover.sv
// Bench for keypad_sprite_mover: a default 80x30 wrapping instance and a small 4x3 clamping one,
// both checked against a position-level reference model.
module tb_keypad_sprite_mover;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] timer;
  logic [7:0]  keypad, keypad_c;

  logic [11:0] vga_addr;
  logic        vga_we;
  logic [15:0] vga_data;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  logic [3:0]  c_addr;
  logic        c_we;
  logic [15:0] c_data;
  logic [1:0]  c_col;
  logic [1:0]  c_row;
  logic        c_busy;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_t;
  int          mc, mr, cc, cr;

  logic [31:0] ha[$], hd[$], ht[$];
  logic [31:0] ea[$], ed[$], qa[$], qd[$];

  keypad_sprite_mover dut (
    .clk(clk), .rst(rst), .timer(timer), .keypad(keypad),
    .vga_addr(vga_addr), .vga_we(vga_we), .vga_data(vga_data),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  keypad_sprite_mover #(
    .COLS(4), .ROWS(3), .ADDR_W(4), .START_COL(0), .START_ROW(1),
    .WRAP(0), .MOVE_DELAY(5)
  ) dut_c (
    .clk(clk), .rst(rst), .timer(timer), .keypad(keypad_c),
    .vga_addr(c_addr), .vga_we(c_we), .vga_data(c_data),
    .cur_col(c_col), .cur_row(c_row), .busy(c_busy)
  );

  always #5 clk = ~clk;

  // Apply keys for the coming edge, then return 1 time unit after it; last_t is the timer seen at that edge
  task automatic applyStimulus(input logic [7:0] k, input logic [7:0] kc);
    keypad   = k;
    keypad_c = kc;
    @(posedge clk);
    #1;
    last_t = timer;
    timer  = timer + 32'd1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(8'h00, 8'h00);
  endtask

  // Grid-level move rule: priority left > right > down > up, then wrap or refuse at the edge
  task automatic model_step(input logic [7:0] k, input int cols, input int rows, input bit wrap,
                            inout int col, inout int row, output bit ok);
    int nc, nr;
    nc = col;
    nr = row;
    ok = 1'b1;
    if (k[0]) nc = col - 1;
    else if (k[1]) nc = col + 1;
    else if (k[2]) nr = row + 1;
    else if (k[3]) nr = row - 1;
    else ok = 1'b0;
    if (ok && (nc < 0 || nc >= cols || nr < 0 || nr >= rows)) begin
      if (wrap) begin
        nc = (nc + cols) % cols;
        nr = (nr + rows) % rows;
      end else begin
        ok = 1'b0;
      end
    end
    if (ok) begin
      col = nc;
      row = nr;
    end
  endtask

  task automatic run_clear_main(input string tag, input int exp_draw);
    int n = 0;
    bit seq_ok = 1'b1, gap = 1'b0, seen = 1'b0;
    logic [31:0] da = '0, dd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      applyStimulus(8'h00, 8'h00);
      if (vga_we) begin
        if (n < 2400) begin
          if (vga_addr != 12'(n) || vga_data != 16'h0000) seq_ok = 1'b0;
        end else if (n == 2400) begin
          da = 32'(vga_addr);
          dd = 32'(vga_data);
        end
        n++;
        seen = 1'b1;
      end else if (seen) begin
        gap = 1'b1;
      end
      if (!busy) break;
    end
    checkOutput({tag, "_finished"}, 32'(busy), 32'd0);
    checkOutput({tag, "_writes"}, 32'(n), 32'd2401);
    checkOutput({tag, "_seq"}, 32'(seq_ok), 32'd1);
    checkOutput({tag, "_gap"}, 32'(gap), 32'd0);
    checkOutput({tag, "_draw_addr"}, da, 32'(exp_draw));
    checkOutput({tag, "_draw_data"}, dd, 32'h0e01);
    applyStimulus(8'h00, 8'h00);
    checkOutput({tag, "_we_after"}, 32'(vga_we), 32'd0);
  endtask

  task automatic do_move_main(input string tag, input logic [7:0] k);
    int  old_a;
    bit  ok;
    old_a = mr * 80 + mc;
    model_step(k, 80, 30, 1'b1, mc, mr, ok);
    applyStimulus(k, 8'h00);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    applyStimulus(8'h00, 8'h00);
    checkOutput({tag, "_erase_we"}, 32'(vga_we), 32'd1);
    checkOutput({tag, "_erase_addr"}, 32'(vga_addr), 32'(old_a));
    checkOutput({tag, "_erase_data"}, 32'(vga_data), 32'h0000);
    applyStimulus(8'h00, 8'h00);
    checkOutput({tag, "_draw_we"}, 32'(vga_we), 32'd1);
    checkOutput({tag, "_draw_addr"}, 32'(vga_addr), 32'(mr * 80 + mc));
    checkOutput({tag, "_draw_data"}, 32'(vga_data), 32'h0e01);
    checkOutput({tag, "_col"}, 32'(cur_col), 32'(mc));
    checkOutput({tag, "_row"}, 32'(cur_row), 32'(mr));
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] k;
    bit         ok;
    int         nw, nb, old_a;

    rst      = 1'b1;
    timer    = 32'hFFFF_F200;
    keypad   = '0;
    keypad_c = '0;
    mc = 10; mr = 10; cc = 0; cr = 1;

    $display("[TB] reset and power-on clear");
    applyStimulus(8'h00, 8'h00);
    applyStimulus(8'h00, 8'h00);
    checkOutput("rst_we", 32'(vga_we), 32'd0);
    checkOutput("rst_addr", 32'(vga_addr), 32'd0);
    checkOutput("rst_data", 32'(vga_data), 32'd0);
    checkOutput("rst_col", 32'(cur_col), 32'd10);
    checkOutput("rst_row", 32'(cur_row), 32'd10);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    run_clear_main("init_clear", 810);
    checkOutput("c_init_busy", 32'(c_busy), 32'd0);
    checkOutput("c_init_col", 32'(c_col), 32'd0);
    checkOutput("c_init_row", 32'(c_row), 32'd1);

    $display("[TB] directed moves");
    idle(110);
    do_move_main("right", 8'h02);
    idle(110);
    do_move_main("up_hi_bits", 8'hE8);
    idle(110);
    do_move_main("down_over_up", 8'h0C);

    $display("[TB] held left+right, rate limit across timer wrap");
    idle(110);
    for (int i = 0; i < 1400 && ha.size() < 24; i++) begin
      applyStimulus(8'h03, 8'h00);
      if (vga_we) begin
        ha.push_back(32'(vga_addr));
        hd.push_back(32'(vga_data));
        ht.push_back(last_t);
      end
    end
    applyStimulus(8'h00, 8'h00);
    checkOutput("hold_writes", 32'(ha.size()), 32'd24);
    for (int i = 0; i < ha.size() / 2; i++) begin
      old_a = mr * 80 + mc;
      model_step(8'h03, 80, 30, 1'b1, mc, mr, ok);
      checkOutput($sformatf("hold%0d_erase_addr", i), ha[2*i], 32'(old_a));
      checkOutput($sformatf("hold%0d_erase_data", i), hd[2*i], 32'h0000);
      checkOutput($sformatf("hold%0d_draw_addr", i), ha[2*i+1], 32'(mr * 80 + mc));
      checkOutput($sformatf("hold%0d_draw_data", i), hd[2*i+1], 32'h0e01);
      checkOutput($sformatf("hold%0d_pair", i), ht[2*i+1] - ht[2*i], 32'd1);
      if (i > 0)
        checkOutput($sformatf("hold%0d_spacing", i), ht[2*i+1] - ht[2*i-1], 32'd102);
    end
    checkOutput("hold_col", 32'(cur_col), 32'(mc));

    $display("[TB] clear request with left also pressed");
    idle(110);
    applyStimulus(8'h11, 8'h00);
    run_clear_main("req_clear", mr * 80 + mc);
    checkOutput("req_clear_col", 32'(cur_col), 32'(mc));
    checkOutput("req_clear_row", 32'(cur_row), 32'(mr));

    $display("[TB] clamp instance");
    nw = 0;
    nb = 0;
    applyStimulus(8'h00, 8'h01);
    nw += int'(c_we);
    nb += int'(c_busy);
    repeat (3) begin
      applyStimulus(8'h00, 8'h00);
      nw += int'(c_we);
      nb += int'(c_busy);
    end
    checkOutput("clamp_no_write", 32'(nw), 32'd0);
    checkOutput("clamp_not_busy", 32'(nb), 32'd0);
    checkOutput("clamp_col", 32'(c_col), 32'd0);

    for (int s = 0; s < 24; s++) begin
      k = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) k[4] = 1'b0;
      ea.delete(); ed.delete(); qa.delete(); qd.delete();
      if (k[4]) begin
        for (int a = 0; a < 12; a++) begin
          ea.push_back(32'(a));
          ed.push_back(32'h0000);
        end
        ea.push_back(32'(cr * 4 + cc));
        ed.push_back(32'h0e01);
      end else begin
        old_a = cr * 4 + cc;
        model_step(k, 4, 3, 1'b0, cc, cr, ok);
        if (ok) begin
          ea.push_back(32'(old_a));
          ed.push_back(32'h0000);
          ea.push_back(32'(cr * 4 + cc));
          ed.push_back(32'h0e01);
        end
      end
      idle(4);
      applyStimulus(8'h00, k);
      for (int i = 0; i < 16; i++) begin
        applyStimulus(8'h00, 8'h00);
        if (c_we) begin
          qa.push_back(32'(c_addr));
          qd.push_back(32'(c_data));
        end
      end
      checkOutput($sformatf("rnd%0d_k%0h_count", s, k), 32'(qa.size()), 32'(ea.size()));
      for (int i = 0; i < ea.size(); i++) begin
        if (i < qa.size()) begin
          checkOutput($sformatf("rnd%0d_addr%0d", s, i), qa[i], ea[i]);
          checkOutput($sformatf("rnd%0d_data%0d", s, i), qd[i], ed[i]);
        end
      end
      checkOutput($sformatf("rnd%0d_col", s), 32'(c_col), 32'(cc));
      checkOutput($sformatf("rnd%0d_row", s), 32'(c_row), 32'(cr));
      checkOutput($sformatf("rnd%0d_busy", s), 32'(c_busy), 32'd0);
    end

    $display("[TB] reset in the middle of a clear");
    idle(110);
    applyStimulus(8'h10, 8'h00);
    repeat (1000) applyStimulus(8'h00, 8'h00);
    checkOutput("midclr_we", 32'(vga_we), 32'd1);
    checkOutput("midclr_addr", 32'(vga_addr), 32'd999);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_we", 32'(vga_we), 32'd0);
    checkOutput("midrst_addr", 32'(vga_addr), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd1);
    checkOutput("midrst_col", 32'(cur_col), 32'd10);
    checkOutput("midrst_row", 32'(cur_row), 32'd10);
    applyStimulus(8'h00, 8'h00);
    rst = 1'b0;
    mc = 10; mr = 10; cc = 0; cr = 1;
    run_clear_main("restart_clear", 810);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
